// File: rtl/alu_mult_unit.sv
// Execute-stage ALU: single-cycle AND/OR/ADD/SUB/SLT plus an iterative
// radix-2 shift-add unsigned multiplier behind a start/busy/done handshake.
module alu_mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    // state | meaning
    // IDLE  | waiting for start
    // MULT  | shift-add iterations in flight, start ignored
    // DONE  | result valid this cycle, start accepted as in IDLE
    typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [2:0] OP_MULT = 3'b011;

    state_t             state, state_next;
    logic [WIDTH-1:0]   mcand, mcand_next;
    logic [WIDTH-1:0]   mlier, mlier_next;
    logic [2*WIDTH-1:0] acc, acc_next;
    logic [CW-1:0]      count, count_next;
    logic [WIDTH-1:0]   result_next, result_hi_next;
    logic               zero_next;
    logic [WIDTH-1:0]   alu_out;
    logic [WIDTH:0]     partial;
    logic [2*WIDTH-1:0] iter_acc;

    always_comb begin
        alu_out = '0;
        case (alucontrol)
            3'b000:  alu_out = a & b;
            3'b001:  alu_out = a | b;
            3'b010:  alu_out = a + b;
            3'b110:  alu_out = a - b;
            3'b111:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: alu_out = '0;
        endcase
    end

    // One multiply step: conditional add into the upper half, keep the carry,
    // then shift the whole accumulator right by one.
    assign partial  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                    + {1'b0, (mlier[0] ? mcand : {WIDTH{1'b0}})};
    assign iter_acc = {partial, acc[WIDTH-1:1]};

    always_comb begin
        state_next     = state;
        mcand_next     = mcand;
        mlier_next     = mlier;
        acc_next       = acc;
        count_next     = count;
        result_next    = result;
        result_hi_next = result_hi;
        zero_next      = zero;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    if (alucontrol == OP_MULT) begin
                        mcand_next = a;
                        mlier_next = b;
                        acc_next   = '0;
                        count_next = '0;
                        state_next = MULT;
                    end else begin
                        result_next    = alu_out;
                        result_hi_next = '0;
                        zero_next      = (alu_out == '0);
                        state_next     = DONE;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            MULT: begin
                acc_next   = iter_acc;
                mlier_next = mlier >> 1;
                count_next = count + CW'(1);
                if (count == LAST) begin
                    result_next    = iter_acc[WIDTH-1:0];
                    result_hi_next = iter_acc[2*WIDTH-1:WIDTH];
                    zero_next      = (iter_acc[WIDTH-1:0] == '0);
                    state_next     = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mcand     <= '0;
            mlier     <= '0;
            acc       <= '0;
            count     <= '0;
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b0;
        end else begin
            state     <= state_next;
            mcand     <= mcand_next;
            mlier     <= mlier_next;
            acc       <= acc_next;
            count     <= count_next;
            result    <= result_next;
            result_hi <= result_hi_next;
            zero      <= zero_next;
        end
    end

    assign busy = (state == MULT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_alu_mult_unit.sv
// Directed self-checking bench for alu_mult_unit (WIDTH=32).
module tb_alu_mult_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  alucontrol;
    logic [31:0] a, b;
    logic [31:0] result, result_hi;
    logic        zero, busy, done;

    int checks = 0;
    int errors = 0;
    int cyc, busy_cnt, done_cnt;

    alu_mult_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .alucontrol(alucontrol),
        .a(a), .b(b), .result(result), .result_hi(result_hi),
        .zero(zero), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the sampling edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb);
        start = 1'b1; alucontrol = op; a = va; b = vb;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for done; counts cycles and busy-high cycles seen.
    task automatic wait_done(output int n, output int nbusy);
        n = 0; nbusy = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
            if (busy) nbusy++;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; alucontrol = 3'b000; a = '0; b = '0;
        @(negedge clk); @(negedge clk);
        check("rst_result", result, 0);
        check("rst_hi", result_hi, 0);
        check("rst_zero", zero, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;
        @(negedge clk);

        issue(3'b010, 5, 7);
        check("add_done", done, 1);
        check("add_result", result, 12);
        check("add_zero", zero, 0);
        check("add_busy", busy, 0);
        @(negedge clk);
        check("add_done_drop", done, 0);

        issue(3'b110, 3, 5);
        check("sub_neg", result, 32'hFFFF_FFFE);
        issue(3'b110, 9, 9);
        check("sub_eq", result, 0);
        check("sub_eq_zero", zero, 1);
        issue(3'b111, 32'hFFFF_FFFF, 1);
        check("slt_true", result, 1);
        issue(3'b111, 1, 32'hFFFF_FFFF);
        check("slt_false", result, 0);
        issue(3'b000, 32'hF0F0_1234, 32'h0FF0_FF00);
        check("and", result, 32'h00F0_1200);
        @(negedge clk);

        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mul_e0_busy", busy, 1);
        check("mul_e0_done", done, 0);
        wait_done(cyc, busy_cnt);
        check("mul_latency", cyc, 32);
        check("mul_busy_cycles", busy_cnt + 1, 32);
        check("mul_busy_end", busy, 0);
        check("mul_lo", result, 32'h0000_0001);
        check("mul_hi", result_hi, 32'hFFFF_FFFE);
        check("mul_zero", zero, 0);

        issue(3'b100, 32'h1234, 32'h5678);
        check("unsup_done", done, 1);
        check("unsup_result", result, 0);
        check("unsup_hi", result_hi, 0);
        check("unsup_zero", zero, 1);
        @(negedge clk);

        issue(3'b011, 6, 7);
        wait_done(cyc, busy_cnt);
        check("mul67_latency", cyc, 32);
        check("mul67_lo", result, 42);
        check("mul67_hi", result_hi, 0);
        @(negedge clk);

        issue(3'b011, 3, 4);
        cyc = 0; done_cnt = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                done_cnt++;
                check("ign_done_cycle", cyc, 32);
                check("ign_result", result, 12);
            end
            if (cyc == 5) begin
                start = 1'b1; alucontrol = 3'b010; a = 1; b = 1;
            end else begin
                start = 1'b0;
            end
        end
        check("ign_done_count", done_cnt, 1);
        check("ign_result_hold", result, 12);

        issue(3'b011, 32'h0001_0000, 32'h0001_0000);
        repeat (10) @(negedge clk);
        check("rst_mid_busy_pre", busy, 1);
        reset = 1'b1;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_result", result, 0);
        check("rst_mid_hi", result_hi, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_no_done", done, 0);
        issue(3'b010, 2, 2);
        check("post_rst_done", done, 1);
        check("post_rst_add", result, 4);
        @(negedge clk);

        issue(3'b010, 1, 1);
        check("b2b_done1", done, 1);
        check("b2b_result1", result, 2);
        issue(3'b001, 32'hF0, 32'h0F);
        check("b2b_done2", done, 1);
        check("b2b_result2", result, 32'hFF);
        @(negedge clk);
        check("b2b_done_drop", done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
